// File: rtl/serial_pkg.sv
// Shared constants for the bit-serial adder: state encoding and default width.
package serial_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int SERIAL_W_DEF = 8;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN,
        S_DONE = ST_DONE
    } state_e;

endpackage

// File: rtl/serial_add_if.sv
// Request/result bundle for serial_add; SERIAL_ADD_SUB_EN adds the sub select.
interface serial_add_if #(parameter int W = 8);
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
`ifdef SERIAL_ADD_SUB_EN
  logic         sub;
`endif
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

`ifdef SERIAL_ADD_SUB_EN
  modport master (output start, a, b, cin, sub, input busy, done, sum, cout);
  modport slave  (input start, a, b, cin, sub, output busy, done, sum, cout);
`else
  modport master (output start, a, b, cin, input busy, done, sum, cout);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout);
`endif
endinterface

// File: rtl/serial_add_full_add.sv
// Single-bit full adder; with SERIAL_ADD_SUB_EN, sub=1 turns it into a full subtractor.
// Pure combinational, zero latency, no backpressure.
module full_add (
  input  logic a,
  input  logic b,
  input  logic cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic sub,
`endif
  output logic sum,
  output logic cout
);
  logic w_a_eff;

`ifdef SERIAL_ADD_SUB_EN
  // Borrow is the add carry with the minuend bit inverted.
  assign w_a_eff = sub ? ~a : a;
`else
  assign w_a_eff = a;
`endif

  assign sum  = a ^ b ^ cin;
  assign cout = (w_a_eff & b) | ((w_a_eff ^ b) & cin);
endmodule

// File: rtl/serial_add.sv
// Bit-serial W-bit adder (LSB first, one bit per clock); optional subtract via SERIAL_ADD_SUB_EN.
// Latency W+1 cycles start-to-done; start is ignored while busy, accepted in IDLE or DONE.
module serial_add
  import serial_pkg::*;
#(
  parameter int W = SERIAL_W_DEF
) (
  input logic        clk,
  input logic        rst_n,
  serial_add_if.slave bus
);
  localparam int CW = $clog2(W) + 1;

  state_e         r_state, w_state_nxt;
  logic [W-1:0]   r_a, r_b, r_res, r_sum;
  logic [CW-1:0]  r_cnt;
  logic           r_carry, r_cout, r_busy, r_done, r_sub;
  logic           w_accept, w_last, w_sum_bit, w_cout_bit;

  full_add u_full_add (
    .a    (r_a[0]),
    .b    (r_b[0]),
    .cin  (r_carry),
`ifdef SERIAL_ADD_SUB_EN
    .sub  (r_sub),
`endif
    .sum  (w_sum_bit),
    .cout (w_cout_bit)
  );

  assign w_last = (r_cnt == CW'(W - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: if (bus.start) begin
        w_accept    = 1'b1;
        w_state_nxt = S_RUN;
      end
      S_RUN: if (w_last) w_state_nxt = S_DONE;
      S_DONE: begin
        w_accept    = bus.start;
        w_state_nxt = bus.start ? S_RUN : S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt == S_RUN);
      r_done  <= (w_state_nxt == S_DONE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_sub   <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_a     <= bus.a;
        r_b     <= bus.b;
        r_carry <= bus.cin;
        r_cnt   <= '0;
`ifdef SERIAL_ADD_SUB_EN
        r_sub   <= bus.sub;
`else
        r_sub   <= 1'b0;
`endif
      end else if (r_state == S_RUN) begin
        r_a     <= r_a >> 1;
        r_b     <= r_b >> 1;
        r_res   <= {w_sum_bit, r_res[W-1:1]};
        r_carry <= w_cout_bit;
        r_cnt   <= r_cnt + 1'b1;
      end
      // Publish on DONE entry so sum/cout are valid in the done cycle.
      if (r_state == S_RUN && w_last) begin
        r_sum  <= {w_sum_bit, r_res[W-1:1]};
        r_cout <= w_cout_bit;
      end
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.sum  = r_sum;
  assign bus.cout = r_cout;
endmodule

// File: tb/tb_serial_add.sv
// Directed bench for serial_add: W=8 protocol cases plus W=4 exhaustive arithmetic.
module tb_serial_add;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  serial_add_if #(.W(8)) if8 ();
  serial_add_if #(.W(4)) if4 ();

  serial_add #(.W(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave));
  serial_add #(.W(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  // One W=8 operation; reports latency, busy count, and whether the old result held until done.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                     input logic [7:0] prev_sum, input logic prev_cout,
                     output int lat, output int nbusy, output logic held, output logic overlap);
    @(negedge clk);
    if8.start = 1'b1; if8.a = a; if8.b = b; if8.cin = cin;
    lat = -1; nbusy = 0; held = 1'b1; overlap = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if8.start = 1'b0;
      if (if8.busy) nbusy++;
      if (if8.busy && if8.done) overlap = 1'b1;
      if (if8.done) begin
        lat = i;
        break;
      end
      if (if8.sum !== prev_sum || if8.cout !== prev_cout) held = 1'b0;
    end
  endtask

  initial begin
    int   lat, nbusy, ndone, t1, t2;
    logic held, overlap, got;

    if8.start = 0; if8.a = 0; if8.b = 0; if8.cin = 0;
    if4.start = 0; if4.a = 0; if4.b = 0; if4.cin = 0;
`ifdef SERIAL_ADD_SUB_EN
    if8.sub = 0; if4.sub = 0;
`endif
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(if8.busy), 0);
    check("rst_done", 32'(if8.done), 0);
    check("rst_sum",  32'(if8.sum), 0);
    check("rst_cout", 32'(if8.cout), 0);
    rst_n = 1'b1;

    op8(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, lat, nbusy, held, overlap);
    check("zero_lat",  32'(lat), 9);
    check("zero_busy", 32'(nbusy), 8);
    check("zero_ovl",  32'(overlap), 0);
    check("zero_sum",  32'(if8.sum), 8'h00);
    check("zero_cout", 32'(if8.cout), 0);

    op8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b0, lat, nbusy, held, overlap);
    check("wrap_lat",  32'(lat), 9);
    check("wrap_sum",  32'(if8.sum), 8'h00);
    check("wrap_cout", 32'(if8.cout), 1);

    op8(8'h5A, 8'h3C, 1'b1, 8'h00, 1'b1, lat, nbusy, held, overlap);
    check("mix_held", 32'(held), 1);
    check("mix_sum",  32'(if8.sum), 8'h97);
    check("mix_cout", 32'(if8.cout), 0);

    // Start during RUN must be ignored.
    @(negedge clk);
    if8.start = 1; if8.a = 8'h12; if8.b = 8'h34; if8.cin = 0;
    ndone = 0; t1 = -1;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (i == 3) begin
        if8.start = 1; if8.a = 8'hFF; if8.b = 8'hFF; if8.cin = 1;
      end else begin
        if8.start = 0;
      end
      if (if8.done) begin
        ndone++;
        if (t1 < 0) t1 = i;
      end
    end
    check("busy_ign_ndone", 32'(ndone), 1);
    check("busy_ign_lat",   32'(t1), 9);
    check("busy_ign_sum",   32'(if8.sum), 8'h46);
    check("busy_ign_cout",  32'(if8.cout), 0);

    // Reset abort in the middle of RUN.
    @(negedge clk);
    if8.start = 1; if8.a = 8'h11; if8.b = 8'h22; if8.cin = 0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if8.start = 0;
    end
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(if8.busy), 0);
    check("abort_sum",  32'(if8.sum), 0);
    check("abort_cout", 32'(if8.cout), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (if8.done) ndone++;
    end
    check("abort_nodone", 32'(ndone), 0);
    op8(8'h80, 8'h80, 1'b1, 8'h00, 1'b0, lat, nbusy, held, overlap);
    check("post_abort_lat",  32'(lat), 9);
    check("post_abort_sum",  32'(if8.sum), 8'h01);
    check("post_abort_cout", 32'(if8.cout), 1);

    // Back-to-back: start held high until accepted in the DONE cycle.
    @(negedge clk);
    if8.start = 1; if8.a = 8'h0F; if8.b = 8'h01; if8.cin = 0;
    t1 = -1; t2 = -1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (t1 >= 0 && i == t1 + 1) if8.start = 0;
      if (if8.done) begin
        if (t1 < 0) begin
          t1 = i;
          check("b2b_sum1", 32'(if8.sum), 8'h10);
          if8.a = 8'h70; if8.b = 8'h10; if8.cin = 1;
        end else if (t2 < 0) begin
          t2 = i;
        end
      end
    end
    check("b2b_lat1", 32'(t1), 9);
    check("b2b_gap",  32'(t2 - t1), 9);
    check("b2b_sum2", 32'(if8.sum), 8'h81);
    check("b2b_cout2", 32'(if8.cout), 0);

`ifdef SERIAL_ADD_SUB_EN
    @(negedge clk);
    if8.sub = 1;
    op8(8'h05, 8'h07, 1'b0, 8'h81, 1'b0, lat, nbusy, held, overlap);
    check("sub_sum",  32'(if8.sum), 8'hFE);
    check("sub_cout", 32'(if8.cout), 1);
    if8.sub = 0;
`endif

    // W=4 exhaustive: {cout,sum} == a+b+cin.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int c = 0; c < 2; c++) begin
          @(negedge clk);
          if4.start = 1; if4.a = 4'(a); if4.b = 4'(b); if4.cin = 1'(c);
          got = 1'b0;
          for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if4.start = 0;
            if (if4.done) begin
              got = 1'b1;
              break;
            end
          end
          check("w4_done", 32'(got), 1);
          check("w4_res", 32'({if4.cout, if4.sum}), 32'(a + b + c));
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/serial_add.md
Name: serial_add

Overview:
- Bit-serial N-bit adder built around one single-bit full-adder cell and a carry flip-flop.
- Accepts two W-bit operands and a carry-in on a start pulse, then processes one bit per clock, LSB first.
- Reports sum and carry-out with a one-cycle done pulse.
- Used where area matters more than latency, and as the additive inverse check for the subtractor datapath (a − b + b == a).

Parameters:
- W, 8, operand/sum width in bits (W ≥ 2).
- CW, $clog2(W)+1, bit-counter width (derived, localparam).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request pulse; sampled only when not busy
- a  input  W  operand A, captured on accepted start
- b  input  W  operand B, captured on accepted start
- cin  input  1  carry-in, captured on accepted start
- busy  output  1  high while bits are being processed
- done  output  1  one-cycle pulse; sum/cout valid
- sum  output  W  result, held until the next completion
- cout  output  1  carry-out of MSB, held with sum

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, busy=0, done=0, sum=0, cout=0, internal shift registers, carry and counter cleared.
- States:
  - IDLE: start=1 → capture a, b, cin; counter=0; go to RUN.
  - RUN: each cycle, feed bit0 of A/B shift registers plus carry flop into full_add. Shift the sum bit into the MSB of the result shift register. Shift A and B right. Update carry and increment counter. After the W-th bit → DONE.
  - DONE: one cycle. done=1, sum ← result shift register, cout ← carry. Then go to IDLE. start=1 in DONE is accepted exactly as in IDLE (back-to-back; next DONE at W+1 later).
- Latency: start sampled at edge k → busy high for cycles k+1..k+W → done high for exactly the cycle after edge k+W+1. Total W+1 cycles start-to-done.
- busy=1 only in RUN. done=1 only in DONE. busy and done are never both high.
- start while busy: ignored. Operands are not recaptured and the in-flight result is unaffected.
- sum/cout change only at DONE entry. They are stable across IDLE and RUN, so the previous result stays visible during a new operation.
- Arithmetic: {cout,sum} = a + b + cin, exact, W+1 bits. Wrap-around is expressed only through cout.
- Operands a/b/cin are don't-care except at the accepting edge.
- Reset mid-operation: immediate abort to reset values. No done pulse is issued for the aborted operation.
- All outputs are registered; there is no combinational path from inputs to outputs.

Optional Feature:
- Macro SERIAL_ADD_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), captured with the operands.
  - sub=1: cell computes full-subtractor bit (diff = a^b^bin, borrow = ~a&b | ~(a^b)&bin). Result is sum = (a − b − cin) mod 2^W; cout = final borrow (1 iff a < b+cin).
  - sub=0: identical to the base block.
- Undefined: no sub port; add only. Timing is identical in both builds.

Decomposition:
- Shared package/include serial_pkg:
  - state encoding localparams ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
  - default width constant SERIAL_W_DEF=8.
- Sub-module full_add: single-bit cell with ports a, b, cin, sum, cout; pure combinational. Under SERIAL_ADD_SUB_EN it also takes sub and produces borrow semantics.
- Top module holds the FSM, counter, shift registers and carry flop.

Test Plan (W=8 unless noted):
- After reset release, a=0x00, b=0x00, cin=0, start pulse → done exactly 9 cycles later, sum=0x00, cout=0; busy high for 8 cycles.
- a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1. Then a=0x5A, b=0x3C, cin=1 → sum=0x97, cout=0. Previous sum (0x00) is held until second done.
- Start pulse 3 cycles into RUN with different operands → ignored; result matches first operands; only one done pulse.
- rst_n low mid-RUN (cycle 4) → busy=0, sum=0, cout=0 immediately. No done pulse. Fresh start after release completes normally.
- Back-to-back: start held high through DONE → second operation accepted in DONE cycle; done pulses 9 cycles apart.
- W=4 exhaustive: all a, b, cin (512 cases) → {cout,sum} == a+b+cin. With SERIAL_ADD_SUB_EN, sub=1, a=0x05, b=0x07, cin=0 → sum=0xFE, cout=1.
